// File: rtl/mod_counter_ext.sv
// Modulo-M up/down counter with IDLE/RUN/DONE control, runtime modulus and
// one-cycle registered overflow/underflow pulses.
module mod_counter_ext #(
  parameter int W       = 8,
  parameter int DEF_MOD = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic         start,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] mod,
  input  logic         up,
  input  logic         oneshot,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         ov,
  output logic         un,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // DEF_MOD = 2^W truncates naturally to an all-ones terminal value.
  localparam logic [W-1:0] DEF_LAST = W'(DEF_MOD - 1);
  localparam logic [W-1:0] ZERO     = {W{1'b0}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic         ov_q, ov_d;
  logic         un_q, un_d;
  logic         busy_q, busy_d;
  logic [W-1:0] m_last_s;
  logic         tc_s;
  logic         step_s;

  // Terminal value M-1 and terminal flag; q >= M-1 keeps out-of-range values terminal.
  always_comb begin
    m_last_s = (mod == ZERO) ? DEF_LAST : (mod - ONE);
    if (up) begin
      tc_s = (q_q >= m_last_s);
    end else begin
      tc_s = (q_q == ZERO);
    end
    step_s = (state_q == RUN) && ce && !clr && !start && !load;
  end

  // Next-state and next-output computation with clr > start > load > step priority.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ov_d    = 1'b0;
    un_d    = 1'b0;
    if (clr) begin
      state_d = IDLE;
      q_d     = ZERO;
    end else if (start) begin
      state_d = RUN;
      q_d     = up ? ZERO : m_last_s;
    end else if (load) begin
      q_d = load_val;
    end else if (step_s) begin
      if (up) begin
        if (tc_s) begin
          ov_d = 1'b1;
          if (oneshot) begin
            state_d = DONE;
          end else begin
            q_d = ZERO;
          end
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (q_q == ZERO) begin
          un_d = 1'b1;
          if (oneshot) begin
            state_d = DONE;
          end else begin
            q_d = m_last_s;
          end
        end else begin
          q_d = q_q - ONE;
        end
      end
    end else begin
      q_d = q_q;
    end
    busy_d = (state_d == RUN);
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= ZERO;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ov_q    <= ov_d;
      un_q    <= un_d;
      busy_q  <= busy_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_s;
  assign ov   = ov_q;
  assign un   = un_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mod_counter_ext.sv
// Scoreboard bench for mod_counter_ext: a behavioural model pushes expected
// results per driven cycle; each scenario task pops and compares after the edge.
module tb_mod_counter_ext;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce, clr, start, load, up, oneshot;
  logic [7:0] load_val, mod;
  logic [7:0] q;
  logic       tc, ov, un, busy;

  mod_counter_ext #(.W(8), .DEF_MOD(10)) dut (
    .clk(clk), .rst(rst), .ce(ce), .clr(clr), .start(start), .load(load),
    .load_val(load_val), .mod(mod), .up(up), .oneshot(oneshot),
    .q(q), .tc(tc), .ov(ov), .un(un), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic       ov;
    logic       un;
    logic       busy;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mq;
  int         ms;  // 0 = IDLE, 1 = RUN, 2 = DONE

  function automatic logic [7:0] m_last();
    logic [7:0] r;
    r = (mod == 8'd0) ? 8'd9 : mod - 8'd1;
    return r;
  endfunction

  function automatic logic exp_tc();
    return up ? (mq >= m_last()) : (mq == 8'd0);
  endfunction

  // Drive one cycle, predict its outcome into the scoreboard, then step past the edge.
  task automatic drive(input logic i_ce, input logic i_clr, input logic i_start,
                       input logic i_load, input logic [7:0] i_lv);
    exp_t x;
    logic t;
    ce = i_ce; clr = i_clr; start = i_start; load = i_load; load_val = i_lv;
    t = exp_tc();
    x.ov = 1'b0;
    x.un = 1'b0;
    if (i_clr) begin
      mq = 8'd0; ms = 0;
    end else if (i_start) begin
      mq = up ? 8'd0 : m_last(); ms = 1;
    end else if (i_load) begin
      mq = i_lv;
    end else if (ms == 1 && i_ce) begin
      if (up) begin
        if (t) begin
          x.ov = 1'b1;
          if (oneshot) ms = 2; else mq = 8'd0;
        end else mq = mq + 8'd1;
      end else begin
        if (mq == 8'd0) begin
          x.un = 1'b1;
          if (oneshot) ms = 2; else mq = m_last();
        end else mq = mq - 8'd1;
      end
    end
    x.q = mq;
    x.busy = (ms == 1);
    sb.push_back(x);
    @(posedge clk);
    #1;
    ce = 1'b0; clr = 1'b0; start = 1'b0; load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; clr = 1'b0; start = 1'b0; load = 1'b0;
    load_val = 8'd0; mod = 8'd0; up = 1'b1; oneshot = 1'b0;
    mq = 8'd0; ms = 0;
    #2;
    checks++;
    if (q !== 8'd0 || ov !== 1'b0 || un !== 1'b0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_up: q=%0d ov=%b un=%b busy=%b tc=%b, expected 0 0 0 0 0", q, ov, un, busy, tc);
    end
    up = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("FAIL reset_tc_down: tc=%b, expected 1", tc);
    end
    up = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap_up();
    logic [7:0] golden [13] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                                8'd8, 8'd9, 8'd0, 8'd1, 8'd2};
    mod = 8'd0; up = 1'b1; oneshot = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 0) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      else drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || q !== golden[i] || ov !== e.ov || ov !== (i == 10) || un !== e.un ||
          busy !== e.busy || tc !== exp_tc()) begin
        errors++;
        $display("FAIL wrap_up[%0d]: q=%0d ov=%b un=%b busy=%b tc=%b, expected q=%0d ov=%b un=%b busy=%b tc=%b",
                 i, q, ov, un, busy, tc, golden[i], e.ov, e.un, e.busy, exp_tc());
      end
    end
  endtask

  task automatic test_oneshot_down();
    mod = 8'd5; up = 1'b0; oneshot = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 0 || i == 8) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      else drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ov !== e.ov || un !== e.un || busy !== e.busy || tc !== exp_tc() ||
          (i == 5 && (un !== 1'b1 || busy !== 1'b0)) || (i == 8 && q !== 8'd4)) begin
        errors++;
        $display("FAIL oneshot_down[%0d]: q=%0d ov=%b un=%b busy=%b tc=%b, expected q=%0d ov=%b un=%b busy=%b tc=%b",
                 i, q, ov, un, busy, tc, e.q, e.ov, e.un, e.busy, exp_tc());
      end
    end
  endtask

  task automatic test_priority();
    mod = 8'd0; up = 1'b1; oneshot = 1'b0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 4:    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        1, 2:    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        3:       drive(1'b1, 1'b1, 1'b1, 1'b1, 8'd77);
        default: drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd55);
      endcase
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ov !== e.ov || un !== e.un || busy !== e.busy || tc !== exp_tc() ||
          (i == 3 && (q !== 8'd0 || busy !== 1'b0)) || (i == 5 && (q !== 8'd0 || busy !== 1'b1))) begin
        errors++;
        $display("FAIL priority[%0d]: q=%0d ov=%b un=%b busy=%b tc=%b, expected q=%0d ov=%b un=%b busy=%b tc=%b",
                 i, q, ov, un, busy, tc, e.q, e.ov, e.un, e.busy, exp_tc());
      end
    end
  endtask

  task automatic test_out_of_range();
    mod = 8'd6; up = 1'b1; oneshot = 1'b0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        2:       drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd200);
        default: drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      endcase
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ov !== e.ov || un !== e.un || busy !== e.busy || tc !== exp_tc() ||
          (i == 2 && (q !== 8'd200 || tc !== 1'b1)) || (i == 3 && (q !== 8'd0 || ov !== 1'b1))) begin
        errors++;
        $display("FAIL out_of_range[%0d]: q=%0d ov=%b un=%b busy=%b tc=%b, expected q=%0d ov=%b un=%b busy=%b tc=%b",
                 i, q, ov, un, busy, tc, e.q, e.ov, e.un, e.busy, exp_tc());
      end
    end
    // Down step from above the modulus decrements without clamping.
    up = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd200);
    void'(sb.pop_front());
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    e = sb.pop_front();
    checks++;
    if (q !== e.q || q !== 8'd199 || un !== 1'b0) begin
      errors++;
      $display("FAIL down_out_of_range: q=%0d un=%b, expected q=199 un=0", q, un);
    end
  endtask

  task automatic test_ce_gating();
    mod = 8'd3; up = 1'b1; oneshot = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      drive(((i % 2) == 0), 1'b0, 1'b0, 1'b0, 8'd0);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ov !== e.ov || un !== e.un || busy !== e.busy || tc !== exp_tc() ||
          (i == 4 && ov !== 1'b1) || (i == 5 && ov !== 1'b0)) begin
        errors++;
        $display("FAIL ce_gating[%0d]: q=%0d ov=%b un=%b busy=%b tc=%b, expected q=%0d ov=%b un=%b busy=%b tc=%b",
                 i, q, ov, un, busy, tc, e.q, e.ov, e.un, e.busy, exp_tc());
      end
    end
  endtask

  task automatic test_mid_reset();
    mod = 8'd0; up = 1'b1; oneshot = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      void'(sb.pop_front());
    end
    checks++;
    if (q !== 8'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre: q=%0d busy=%b, expected q=7 busy=1", q, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 8'd0 || busy !== 1'b0 || ov !== 1'b0 || un !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: q=%0d busy=%b ov=%b un=%b, expected 0 0 0 0", q, busy, ov, un);
    end
    #1 rst = 1'b0;
    mq = 8'd0; ms = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ov !== 1'b0 || un !== 1'b0 || busy !== e.busy || tc !== exp_tc()) begin
        errors++;
        $display("FAIL mid_reset_after[%0d]: q=%0d ov=%b un=%b busy=%b, expected q=%0d ov=0 un=0 busy=%b",
                 i, q, ov, un, busy, e.q, e.busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_oneshot_down();
    test_priority();
    test_out_of_range();
    test_ce_gating();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
